// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the clear-engine state encoding and the byte-mask expansion helper.
// Imported by the register file top and its clear FSM.
package regfile_pkg;

    // Clear engine states: idle, sweeping, one-cycle completion.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    localparam int BYTE_W = 8;

    // Widest register the mask helper supports; callers truncate the result.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / BYTE_W;

    // Expand one enable bit per byte into a full bit mask.
    function automatic logic [MAX_DATA_W-1:0] expandByteMask(input logic [MAX_BE_W-1:0] be);
        logic [MAX_DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_BE_W; i++) begin
            mask[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear engine: walks every register index once, one per cycle, on request.
// Sweep takes DEPTH cycles in CLEAR plus one DONE cycle; clrReq is a single-cycle pulse.
// Blocks writes (wrReady low) from the cycle after the request until back in IDLE.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clrReq,
    output logic              busy,
    output logic              clrDone,
    output logic              wrReady,
    output logic              clrEn,
    output logic [ADDR_W-1:0] clrAddr
);

    // Highest index; reaching it ends the sweep so the counter never wraps into a new pass.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_t        state;
    clr_state_t        stateNext;
    logic [ADDR_W-1:0] sweepCnt;
    logic [ADDR_W-1:0] sweepCntNext;

    // State and sweep counter registers; reset abandons any sweep in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sweepCnt <= '0;
        end else begin
            state    <= stateNext;
            sweepCnt <= sweepCntNext;
        end
    end

    // Next-state, counter advance and per-state outputs.
    always_comb begin
        stateNext    = state;
        sweepCntNext = sweepCnt;
        busy         = 1'b0;
        clrDone      = 1'b0;
        wrReady      = 1'b0;
        clrEn        = 1'b0;
        clrAddr      = sweepCnt;
        case (state)
            IDLE: begin
                wrReady = 1'b1;
                if (clrReq) begin
                    stateNext    = CLEAR;
                    sweepCntNext = '0;
                end
            end
            CLEAR: begin
                busy         = 1'b1;
                clrEn        = 1'b1;
                sweepCntNext = sweepCnt + ADDR_W'(1);
                if (sweepCnt == LAST_ADDR) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                clrDone   = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read, single-write register file with byte enables, optional bypass and a clear sweep.
// Reads are combinational (zero latency); writes land on the next rising edge.
// Writes use valid/ready: wr_ready drops while the clear engine runs and for its DONE cycle.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int N_RD     = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/BYTE_W-1:0] wr_be,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     clr_done
);

    logic [DATA_W-1:0] regs [DEPTH];

    logic              clrEn;
    logic [ADDR_W-1:0] clrAddr;
    logic              wrFire;
    logic              wrToZero;
    logic [DATA_W-1:0] wrMask;

    regfile_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk     (clk),
        .reset   (reset),
        .clrReq  (clr_req),
        .busy    (busy),
        .clrDone (clr_done),
        .wrReady (wr_ready),
        .clrEn   (clrEn),
        .clrAddr (clrAddr)
    );

    assign wrFire   = wr_valid & wr_ready;
    // Register 0 is hardwired when ZERO_REG is set, so writes to it are dropped.
    assign wrToZero = (ZERO_REG != 0) && (wr_addr == '0);
    assign wrMask   = DATA_W'(expandByteMask(MAX_BE_W'(wr_be)));

    // Storage: reset zeroes everything; the sweep and writes never overlap because
    // wr_ready is low whenever clrEn is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clrEn) begin
            regs[clrAddr] <= '0;
        end else if (wrFire && !wrToZero) begin
            regs[wr_addr] <= (regs[wr_addr] & ~wrMask) | (wr_data & wrMask);
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : gRd
        logic [ADDR_W-1:0] rdAddr;
        logic [DATA_W-1:0] stored;
        logic [DATA_W-1:0] rdPort;
        logic              isZero;
        logic              hit;

        assign rdAddr = rd_addr[k*ADDR_W +: ADDR_W];
        assign stored = regs[rdAddr];
        assign isZero = (ZERO_REG != 0) && (rdAddr == '0);
        assign hit    = (BYPASS != 0) && wrFire && (rdAddr == wr_addr) && !isZero;

        // Read mux: zero during a sweep or for the hardwired register, else forward
        // enabled bytes of a same-cycle write over the stored value.
        always_comb begin
            rdPort = stored;
            if (busy || isZero) begin
                rdPort = '0;
            end else if (hit) begin
                rdPort = (stored & ~wrMask) | (wr_data & wrMask);
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rdPort;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench: two register file configurations against a behavioural model.
// Directed scenarios first, then randomized traffic with occasional clear sweeps.
// Outputs are sampled on the falling edge or shortly after the rising edge.
module tb_regfile_multiport;

    logic clk;
    logic reset;

    // Instance A: 32 x 32-bit, 2 read ports, bypass on.
    logic [9:0]   rdAddrA;
    logic [63:0]  rdDataA;
    logic         wrValidA;
    logic         wrReadyA;
    logic [4:0]   wrAddrA;
    logic [31:0]  wrDataA;
    logic [3:0]   wrBeA;
    logic         clrReqA;
    logic         busyA;
    logic         clrDoneA;

    // Instance B: 16 x 64-bit, 4 read ports, bypass off.
    logic [15:0]  rdAddrB;
    logic [255:0] rdDataB;
    logic         wrValidB;
    logic         wrReadyB;
    logic [3:0]   wrAddrB;
    logic [63:0]  wrDataB;
    logic [7:0]   wrBeB;
    logic         clrReqB;
    logic         busyB;
    logic         clrDoneB;

    int nChecks = 0;
    int nFail   = 0;

    // Reference model: register contents plus cycles elapsed since a clear request
    // (0 = idle, 1..DEPTH = sweeping, DEPTH+1 = done cycle).
    logic [31:0] mA [32];
    logic [63:0] mB [16];
    int          ageA;
    int          ageB;

    regfile_multiport #(
        .DATA_W(32), .DEPTH(32), .N_RD(2), .BYPASS(1), .ZERO_REG(1)
    ) dutA (
        .clk(clk), .reset(reset),
        .rd_addr(rdAddrA), .rd_data(rdDataA),
        .wr_valid(wrValidA), .wr_ready(wrReadyA),
        .wr_addr(wrAddrA), .wr_data(wrDataA), .wr_be(wrBeA),
        .clr_req(clrReqA), .busy(busyA), .clr_done(clrDoneA)
    );

    regfile_multiport #(
        .DATA_W(64), .DEPTH(16), .N_RD(4), .BYPASS(0), .ZERO_REG(1)
    ) dutB (
        .clk(clk), .reset(reset),
        .rd_addr(rdAddrB), .rd_data(rdDataB),
        .wr_valid(wrValidB), .wr_ready(wrReadyB),
        .wr_addr(wrAddrB), .wr_data(wrDataB), .wr_be(wrBeB),
        .clr_req(clrReqB), .busy(busyB), .clr_done(clrDoneB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] expRdA(input logic [4:0] a);
        logic [31:0] v;
        if (ageA >= 1 && ageA <= 32) return 32'h0;
        if (a == 5'd0) return 32'h0;
        v = mA[a];
        if (ageA == 0 && wrValidA && a == wrAddrA) begin
            for (int i = 0; i < 4; i++) begin
                if (wrBeA[i]) v[i*8 +: 8] = wrDataA[i*8 +: 8];
            end
        end
        return v;
    endfunction

    function automatic logic [63:0] expRdB(input logic [3:0] a);
        if (ageB >= 1 && ageB <= 16) return 64'h0;
        if (a == 4'd0) return 64'h0;
        return mB[a];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mA[i] = '0;
        for (int i = 0; i < 16; i++) mB[i] = '0;
        ageA = 0;
        ageB = 0;
    endtask

    task automatic modelEdge();
        if (ageA == 0) begin
            if (wrValidA && wrAddrA != 5'd0) begin
                for (int i = 0; i < 4; i++) begin
                    if (wrBeA[i]) mA[wrAddrA][i*8 +: 8] = wrDataA[i*8 +: 8];
                end
            end
            if (clrReqA) begin
                for (int i = 0; i < 32; i++) mA[i] = '0;
                ageA = 1;
            end
        end else if (ageA == 33) ageA = 0;
        else ageA++;

        if (ageB == 0) begin
            if (wrValidB && wrAddrB != 4'd0) begin
                for (int i = 0; i < 8; i++) begin
                    if (wrBeB[i]) mB[wrAddrB][i*8 +: 8] = wrDataB[i*8 +: 8];
                end
            end
            if (clrReqB) begin
                for (int i = 0; i < 16; i++) mB[i] = '0;
                ageB = 1;
            end
        end else if (ageB == 17) ageB = 0;
        else ageB++;
    endtask

    task automatic checkOutputs();
        checkVal("busyA",  64'(busyA),    64'(ageA >= 1 && ageA <= 32));
        checkVal("doneA",  64'(clrDoneA), 64'(ageA == 33));
        checkVal("readyA", 64'(wrReadyA), 64'(ageA == 0));
        for (int k = 0; k < 2; k++) begin
            checkVal($sformatf("rdA%0d", k), 64'(rdDataA[k*32 +: 32]), 64'(expRdA(rdAddrA[k*5 +: 5])));
        end
        checkVal("busyB",  64'(busyB),    64'(ageB >= 1 && ageB <= 16));
        checkVal("doneB",  64'(clrDoneB), 64'(ageB == 17));
        checkVal("readyB", 64'(wrReadyB), 64'(ageB == 0));
        for (int k = 0; k < 4; k++) begin
            checkVal($sformatf("rdB%0d", k), rdDataB[k*64 +: 64], expRdB(rdAddrB[k*4 +: 4]));
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        checkOutputs();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic idleInputs();
        wrValidA = 1'b0; wrAddrA = '0; wrDataA = '0; wrBeA = '0; clrReqA = 1'b0; rdAddrA = '0;
        wrValidB = 1'b0; wrAddrB = '0; wrDataB = '0; wrBeB = '0; clrReqB = 1'b0; rdAddrB = '0;
    endtask

    task automatic writeA(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wrValidA = 1'b1; wrAddrA = a; wrDataA = d; wrBeA = be;
        tick();
        wrValidA = 1'b0;
    endtask

    int busyCnt;
    int doneCnt;
    int doneAt;
    int readyDuring;

    initial begin
        idleInputs();
        modelReset();
        reset = 1'b1;
        #12;
        checkVal("rst_busy", 64'(busyA), 64'd0);
        checkVal("rst_done", 64'(clrDoneA), 64'd0);
        checkVal("rst_rd",   rdDataA, 64'd0);
        reset = 1'b0;
        #1;
        checkVal("rst_ready", 64'(wrReadyA), 64'd1);
        tick();

        // Byte enables.
        writeA(5'd7, 32'h11223344, 4'hF);
        writeA(5'd7, 32'hAABBCCDD, 4'b0101);
        rdAddrA = {5'd7, 5'd7};
        #1;
        checkVal("be_r7", 64'(rdDataA[31:0]), 64'h11BB33DD);
        tick();

        // Zero register, including the write cycle itself.
        rdAddrA = '0;
        wrValidA = 1'b1; wrAddrA = 5'd0; wrDataA = 32'hFFFFFFFF; wrBeA = 4'hF;
        #1;
        checkVal("zero_wr_p0", 64'(rdDataA[31:0]),  64'd0);
        checkVal("zero_wr_p1", 64'(rdDataA[63:32]), 64'd0);
        tick();
        wrValidA = 1'b0;
        #1;
        checkVal("zero_after", 64'(rdDataA[31:0]), 64'd0);

        // Bypass on both ports.
        writeA(5'd3, 32'h00000010, 4'hF);
        rdAddrA = {5'd3, 5'd3};
        wrValidA = 1'b1; wrAddrA = 5'd3; wrDataA = 32'h12345678; wrBeA = 4'b1100;
        #1;
        checkVal("byp_p0", 64'(rdDataA[31:0]),  64'h12340010);
        checkVal("byp_p1", 64'(rdDataA[63:32]), 64'h12340010);
        tick();
        wrValidA = 1'b0;

        // Wide, no-bypass instance: old value during the write, new one afterwards.
        rdAddrB = {4{4'hF}};
        wrValidB = 1'b1; wrAddrB = 4'hF; wrDataB = 64'h0123456789ABCDEF; wrBeB = 8'hFF;
        #1;
        for (int k = 0; k < 4; k++) checkVal($sformatf("nobyp_old%0d", k), rdDataB[k*64 +: 64], 64'd0);
        tick();
        wrValidB = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) checkVal($sformatf("nobyp_new%0d", k), rdDataB[k*64 +: 64], 64'h0123456789ABCDEF);

        // Clear sweep with a write held pending across it.
        for (int i = 1; i < 32; i++) writeA(5'(i), 32'(i), 4'hF);
        clrReqA = 1'b1;
        tick();
        clrReqA = 1'b0;
        wrValidA = 1'b1; wrAddrA = 5'd9; wrDataA = 32'h55; wrBeA = 4'hF;
        busyCnt = 0; doneCnt = 0; doneAt = 0; readyDuring = 0;
        for (int k = 1; k <= 35; k++) begin
            if (k == 35) wrValidA = 1'b0;
            if (busyA) busyCnt++;
            if (clrDoneA) begin doneCnt++; doneAt = k; end
            if (k <= 33 && wrReadyA) readyDuring++;
            tick();
        end
        checkVal("sweep_busy_cycles", 64'(busyCnt), 64'd32);
        checkVal("sweep_done_count",  64'(doneCnt), 64'd1);
        checkVal("sweep_done_cycle",  64'(doneAt), 64'd33);
        checkVal("sweep_ready_low",   64'(readyDuring), 64'd0);
        rdAddrA = {5'd10, 5'd9};
        #1;
        checkVal("sweep_r9_late_wr", 64'(rdDataA[31:0]), 64'h55);
        checkVal("sweep_r10_zero",   64'(rdDataA[63:32]), 64'd0);
        for (int a = 0; a < 32; a++) begin
            rdAddrA = {5'(31 - a), 5'(a)};
            tick();
        end

        // Reset in the middle of a sweep.
        writeA(5'd5, 32'hDEADBEEF, 4'hF);
        clrReqA = 1'b1;
        tick();
        clrReqA = 1'b0;
        tick(); tick(); tick();
        rdAddrA = {5'd5, 5'd5};
        reset = 1'b1;
        #1;
        modelReset();
        checkVal("midrst_busy", 64'(busyA), 64'd0);
        checkVal("midrst_done", 64'(clrDoneA), 64'd0);
        checkVal("midrst_r5",   64'(rdDataA[31:0]), 64'd0);
        reset = 1'b0;
        #1;
        checkVal("midrst_ready", 64'(wrReadyA), 64'd1);
        tick();
        checkVal("midrst_r5_after", 64'(rdDataA[31:0]), 64'd0);

        // Randomized traffic on both instances.
        for (int n = 0; n < 900; n++) begin
            wrValidA = 1'($urandom_range(0, 1));
            wrAddrA  = 5'($urandom);
            wrDataA  = $urandom;
            wrBeA    = 4'($urandom);
            clrReqA  = ($urandom_range(0, 79) == 0);
            rdAddrA[4:0] = ($urandom_range(0, 2) == 0) ? wrAddrA : 5'($urandom);
            rdAddrA[9:5] = ($urandom_range(0, 2) == 0) ? wrAddrA : 5'($urandom);
            wrValidB = 1'($urandom_range(0, 1));
            wrAddrB  = 4'($urandom);
            wrDataB  = {$urandom, $urandom};
            wrBeB    = 8'($urandom);
            clrReqB  = ($urandom_range(0, 79) == 0);
            for (int k = 0; k < 4; k++) begin
                rdAddrB[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? wrAddrB : 4'($urandom);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-write, two-read CPU register file.
- Adds the following:
  - configurable data width, register count and number of read ports
  - byte-enabled writes through a valid/ready handshake
  - optional same-cycle write-to-read bypass
  - a sequential clear engine that zeroes the file one register per cycle on request
- Sits in the decode stage; read data feeds the operand latches, and the write port is driven from writeback.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), address width (derived).
- N_RD, 2, number of read ports, 1..4.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  N_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  N_RD*DATA_W  packed read data, combinational from rd_addr.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when high together with wr_valid.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
- clr_req  in  1  single-cycle pulse that starts a clear sweep.
- busy  out  1  high while the clear engine runs.
- clr_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset: asserting reset, at any time including mid-sweep, immediately applies all of the following:
  - every register becomes 0
  - FSM goes to IDLE and the sweep counter to 0
  - busy=0, clr_done=0, wr_ready=1 once reset deasserts
- Write fire: wr_valid & wr_ready.
  - On the rising clk edge, each byte i with wr_be[i]=1 is updated.
  - A fire with wr_be all zero, or wr_addr=0 when ZERO_REG=1, leaves storage unchanged.
  - wr_ready = (state==IDLE).
- Reads:
  - Combinational, zero latency.
  - rd_addr=0 with ZERO_REG=1 returns 0 regardless of bypass.
  - Read ports are independent; duplicate addresses are legal.
- Bypass (BYPASS=1):
  - Applies when there is a write fire and rd_addr==wr_addr on a non-zero register.
  - Bytes with wr_be set come from wr_data; the other bytes come from stored data.
  - With BYPASS=0, rd_data shows old data until the next cycle.
- FSM states: IDLE, CLEAR, DONE.
- IDLE:
  - clr_req=1 moves to CLEAR with counter=0 and busy=1 from the next cycle.
  - A write firing in the same cycle as clr_req is still performed, then overwritten by the sweep.
- CLEAR:
  - Each cycle, register[counter] is set to 0 and counter increments.
  - When counter==DEPTH-1 is written, the next state is DONE.
  - The sweep takes exactly DEPTH cycles.
  - clr_req is ignored while in CLEAR.
  - While in CLEAR, wr_ready=0 and every rd_data port returns 0.
- DONE:
  - Lasts one cycle: clr_done=1, busy=0, wr_ready=0.
  - Then returns to IDLE.
- Counter wraps: the ADDR_W-bit counter is never compared past DEPTH-1 and does not overflow into a new sweep.
- Storage holds no X after reset; a read of any address returns a defined value.

Decomposition:
- Package regfile_pkg contains:
  - clr_state_t enum {IDLE, CLEAR, DONE}
  - BYTE_W=8 constant
  - a byte-mask expansion function (wr_be to a DATA_W bit mask)
- Sub-module regfile_clear_fsm contains:
  - the state register and sweep counter
  - outputs busy, clr_done, wr_ready and the internal clear-address/clear-enable signals
- Storage, read muxing and bypass stay in the top module.

Test Plan:
- Reset mid-sweep:
  - Stimulus: write 0xDEADBEEF to r5 with be=4'hF; issue clr_req; after 3 cycles, pulse reset.
  - Response: busy=0 immediately; r5 reads 0; wr_ready=1 after release.
- Byte enables:
  - Stimulus: write 0x11223344 to r7 with be=4'hF, then 0xAABBCCDD to r7 with be=4'b0101.
  - Response: r7 reads 0x11BB33DD.
- Zero register:
  - Stimulus: write 0xFFFFFFFF to r0.
  - Response: all read ports at addr 0 return 0, including during the write cycle.
- Bypass (BYPASS=1):
  - Stimulus: r3=0x00000010 stored; write 0x12345678 to r3 with be=4'b1100 while rd_addr port0=3 and port1=3.
  - Response: both ports read 0x12340010 in the same cycle.
- Clear sweep (DEPTH=32):
  - Stimulus: fill r1..r31 with their index; pulse clr_req.
  - Response:
    - busy high for exactly 32 cycles
    - wr_ready=0 throughout
    - clr_done pulses once on cycle 33
    - all registers read 0 afterwards
    - a wr_valid held during the sweep fires only once the FSM is back in IDLE
- Parameter sweep: N_RD=4, DATA_W=64, DEPTH=16, BYPASS=0.
  - Stimulus: write 0x0123456789ABCDEF to r15 while reading r15 on all four ports.
  - Response: old value (0) in the write cycle, then the new value on all ports the next cycle.
